adc_conversion_sequencer: RTL and testbench

Master-side sequencer for the 12-bit serial ADC channel. It derives SCLK and CS from the system clock and paces conversions either periodically or on demand. It shifts the 16-bit SDATA frame in and presents the 12-bit result with a one-cycle done tick. It replaces the free-running SCLK/CS stimulus used in the loopback harness and sits between the ADC pins and the sample-consuming logic.

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_sclk_gen.sv | 39 +++
 rtl/adc_conversion_sequencer.sv | 108 ++++++++++
 tb/tb_adc_conversion_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared encodings and frame geometry for the serial ADC conversion sequencer.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_BITS  = 4;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: half-period counter plus SCLK flop, idles high while run=0.
// rise_stb/fall_stb are high in the cycle whose closing edge drives SCLK 0->1 / 1->0.
module adc_sclk_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] half_cnt;
  logic          half_end;

  // half_cnt is forced to 0 whenever run is low, so the strobes cannot fire while idle.
  assign half_end = (half_cnt == CW'(CLK_DIV - 1));
  assign rise_stb = half_end && !sclk;
  assign fall_stb = half_end && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      sclk     <= 1'b1;
    end else if (!run) begin
      half_cnt <= '0;
      sclk     <= 1'b1;
    end else if (half_end) begin
      half_cnt <= '0;
      sclk     <= ~sclk;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_conversion_sequencer.sv
// Master-side sequencer for the 12-bit serial ADC: paces conversions, drives CS/SCLK,
// shifts in the 16-bit frame and presents the sample with a one-cycle done tick.
module adc_conversion_sequencer
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 5,
  parameter int SAMPLE_PERIOD = 2000,
  parameter int QUIET_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        SDATA,
  output logic        SCLK,
  output logic        CS,
  output logic [11:0] data_Out,
  output logic        rx_done_tick,
  output logic        lead_err,
  output logic        busy,
  output logic        missed,
  output logic [2:0]  state_dbg
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int RW = $clog2(FRAME_BITS + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);

  state_t                state, next_state;
  logic [PW-1:0]         per_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic [RW-1:0]         rise_cnt;
  logic [QW-1:0]         quiet_cnt;
  logic                  trig, req, run, last_fall;
  logic                  rise_stb, fall_stb;

  assign trig      = enable && (per_cnt == PW'(SAMPLE_PERIOD - 1));
  assign req       = start || trig;
  // The falling strobe after the 16th rising edge ends the frame; SCLK must stay high there.
  assign last_fall = fall_stb && (rise_cnt == RW'(FRAME_BITS));
  assign run       = (state == SETUP) || ((state == SHIFT) && !last_fall);
  assign state_dbg = state;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_n    (reset),
    .run      (run),
    .sclk     (SCLK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = SETUP;
      SETUP:   if (fall_stb) next_state = SHIFT;
      SHIFT:   if (last_fall) next_state = DONE;
      DONE:    next_state = (QUIET_CYCLES > 1) ? QUIET : IDLE;
      QUIET:   if (int'(quiet_cnt) + 2 >= QUIET_CYCLES) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      per_cnt      <= '0;
      shift_q      <= '0;
      rise_cnt     <= '0;
      quiet_cnt    <= '0;
      CS           <= 1'b1;
      busy         <= 1'b0;
      rx_done_tick <= 1'b0;
      data_Out     <= '0;
      lead_err     <= 1'b0;
      missed       <= 1'b0;
    end else begin
      state        <= next_state;
      // Flag outputs are registered from next_state so they line up with the state change.
      CS           <= !((next_state == SETUP) || (next_state == SHIFT));
      busy         <= (next_state != IDLE);
      rx_done_tick <= (next_state == DONE);

      if (!enable || trig) per_cnt <= '0;
      else                 per_cnt <= per_cnt + 1'b1;

      if (!enable)                       missed <= 1'b0;
      else if (trig && (state != IDLE))  missed <= 1'b1;

      if (state == IDLE) begin
        rise_cnt <= '0;
      end else if ((state == SHIFT) && rise_stb) begin
        shift_q  <= {shift_q[FRAME_BITS-2:0], SDATA};
        rise_cnt <= rise_cnt + 1'b1;
      end

      if (next_state == DONE) begin
        data_Out <= shift_q[DATA_BITS-1:0];
        lead_err <= |shift_q[FRAME_BITS-1 -: LEAD_BITS];
      end

      if (state == QUIET) quiet_cnt <= quiet_cnt + 1'b1;
      else                quiet_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Bench for adc_conversion_sequencer: ADC pin model, cycle-level reference model and
// expected-sample scoreboard for the default instance, plus a short-period instance.
module tb_adc_conversion_sequencer;

  localparam int CLK_DIV   = 5;
  localparam int SP        = 2000;
  localparam int QC        = 4;
  localparam int SP2       = 150;
  localparam int FRAME_LOW = 33 * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic        enable = 1'b0, start = 1'b0, sdata = 1'b0;
  logic        sclk, cs, rx_done_tick, lead_err, busy, missed;
  logic [11:0] data_out;
  logic [2:0]  state_dbg;

  logic        enable2 = 1'b0, start2 = 1'b0, sdata2 = 1'b0;
  logic        sclk2, cs2, rx_done_tick2, lead_err2, busy2, missed2;
  logic [11:0] data_out2;
  logic [2:0]  state_dbg2;

  adc_conversion_sequencer #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .QUIET_CYCLES(QC)) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .start(start), .SDATA(sdata),
    .SCLK(sclk), .CS(cs), .data_Out(data_out), .rx_done_tick(rx_done_tick),
    .lead_err(lead_err), .busy(busy), .missed(missed), .state_dbg(state_dbg)
  );

  adc_conversion_sequencer #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP2), .QUIET_CYCLES(QC)) dut2 (
    .clk(clk), .reset(rst_n), .enable(enable2), .start(start2), .SDATA(sdata2),
    .SCLK(sclk2), .CS(cs2), .data_Out(data_out2), .rx_done_tick(rx_done_tick2),
    .lead_err(lead_err2), .busy(busy2), .missed(missed2), .state_dbg(state_dbg2)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input int act, input int exp);
    n_tests++;
    n_fail++;
    if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- ADC pin model ----------------
  // Serves words[] in order, one word per CS low period, MSB first; the next bit
  // appears just after each SCLK rise so the master samples a stable bit.
  logic [15:0] words [256];
  logic [15:0] cur_word = '0;
  int          adc_idx = 0;
  int          bit_idx = 0;

  always @(negedge cs) begin
    if (rst_n) begin
      cur_word = words[adc_idx % 256];
      adc_idx++;
      bit_idx = 15;
      sdata = cur_word[15];
    end
  end

  always @(posedge sclk) begin
    if (!cs && bit_idx > 0) begin
      #1;
      bit_idx--;
      sdata = cur_word[bit_idx];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // exp_q entry: {tick cycle[31:0], lead_err, data[11:0]}
  logic [44:0] exp_q[$];
  int          tick_times[$];
  int          n_ticks = 0;
  int          acc_idx = 0;
  int          m_timer = 0, m_acc = 0, m_free = 0;
  bit          m_active = 0, m_missed = 0;
  logic [12:0] exp_hold = '0;
  int          rises = 0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b1;

  always @(negedge clk) begin : monitor_and_model
    logic [44:0] e;
    logic [15:0] w;
    bit          in_frame, in_busy, trig;
    if (!rst_n) begin
      exp_q.delete();
      m_timer = 0; m_acc = 0; m_free = 0; m_active = 0; m_missed = 0;
      exp_hold = '0; rises = 0; cs_prev = 1'b1; sclk_prev = 1'b1;
    end else begin
      // Compare outputs produced by edge 'cyc' against the model.
      in_frame = m_active && cyc >= m_acc && cyc < m_acc + FRAME_LOW;
      in_busy  = m_active && cyc >= m_acc && cyc < m_free - 1;
      check("cs_window", cs, !in_frame);
      check("busy_window", busy, in_busy);
      check("missed_flag", missed, m_missed);
      if (cs) check("sclk_idle_high", sclk, 1'b1);
      if (!cs && sclk && !sclk_prev) rises++;
      if (cs && !cs_prev) begin
        check("sclk_rises_per_frame", rises, 16);
        rises = 0;
      end
      cs_prev = cs;
      sclk_prev = sclk;

      if (rx_done_tick) begin
        if (exp_q.size() == 0) begin
          fail_event("unexpected_done_tick", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_tick_cycle", cyc, e[44:13]);
          check("sample_lead_data", {lead_err, data_out}, e[12:0]);
          exp_hold = e[12:0];
          n_ticks++;
          tick_times.push_back(cyc);
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][44:13]) < cyc) begin
        fail_event("done_tick_missing", 0, int'(exp_q[0][44:13]));
        void'(exp_q.pop_front());
      end
      check("sample_held", {lead_err, data_out}, exp_hold);

      // Decide what the next edge (cyc+1) does with the inputs now on the pins.
      trig = enable && (m_timer == SP - 1);
      m_timer = (!enable || trig) ? 0 : m_timer + 1;
      if ((start || trig) && (cyc + 1 >= m_free)) begin
        m_acc    = cyc + 1;
        m_free   = m_acc + FRAME_LOW + QC + 1;
        m_active = 1;
        w = words[acc_idx % 256];
        acc_idx++;
        exp_q.push_back({32'(m_acc + FRAME_LOW), |w[15:12], w[11:0]});
      end else if (trig) begin
        m_missed = 1;
      end
      if (!enable) m_missed = 0;
    end
  end

  // ---------------- short-period instance monitor ----------------
  int   low2 = 0, high2 = 0, n_ticks2 = 0;
  bit   seen2 = 0;
  logic cs2_prev = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      low2 = 0; high2 = 0; seen2 = 0; cs2_prev = 1'b1;
    end else begin
      if (cs2 && !cs2_prev) begin
        check("dut2_cs_low_len", low2, FRAME_LOW);
        low2 = 0;
        high2 = 0;
      end
      if (!cs2 && cs2_prev) begin
        if (seen2) check("dut2_cs_gap_ge_quiet", high2 >= QC, 1'b1);
        seen2 = 1;
      end
      if (cs2) high2++;
      else     low2++;
      if (rx_done_tick2) n_ticks2++;
      cs2_prev = cs2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, base2, k;
    for (int i = 0; i < 256; i++) words[i] = 16'($urandom_range(0, 65535));
    words[0] = 16'h0ABC;
    words[1] = 16'hF123;

    rst_n = 1'b0;
    step(5);
    check("reset_cs", cs, 1'b1);
    check("reset_sclk", sclk, 1'b1);
    check("reset_data", data_out, 12'h000);
    check("reset_tick", rx_done_tick, 1'b0);
    check("reset_lead", lead_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_missed", missed, 1'b0);
    check("reset_state", state_dbg, 3'd0);
    check("reset2_outputs", {cs2, sclk2, lead_err2, data_out2, state_dbg2}, {1'b1, 1'b1, 1'b0, 12'h000, 3'd0});
    rst_n = 1'b1;
    step(5);

    // Directed frames
    pulse_start();
    step(200);
    check("data_0abc", data_out, 12'hABC);
    check("lead_0abc", lead_err, 1'b0);
    pulse_start();
    step(200);
    check("data_f123", data_out, 12'h123);
    check("lead_f123", lead_err, 1'b1);

    // Random start spacing, some landing while busy
    repeat (10) begin
      pulse_start();
      step($urandom_range(20, 260));
    end
    step(200);

    // Start pulses every 50 cycles while busy yield one frame
    base = n_ticks;
    pulse_start();
    repeat (3) begin
      step(49);
      pulse_start();
    end
    step(250);
    check("repeat_start_frames", n_ticks - base, 1);
    check("repeat_start_missed", missed, 1'b0);

    // Periodic conversions
    base = n_ticks;
    enable = 1'b1;
    step(10000);
    enable = 1'b0;
    step(200);
    check("periodic_frames", n_ticks - base, 5);
    k = n_ticks - base;
    for (int i = 1; i < k; i++)
      check("periodic_spacing", tick_times[base + i] - tick_times[base + i - 1], SP);
    check("periodic_missed", missed, 1'b0);

    // Reset 80 cycles into a frame
    pulse_start();
    step(79);
    rst_n = 1'b0;
    #1;
    check("midreset_cs", cs, 1'b1);
    check("midreset_sclk", sclk, 1'b1);
    check("midreset_data", data_out, 12'h000);
    check("midreset_busy", busy, 1'b0);
    step(3);
    rst_n = 1'b1;
    words[acc_idx % 256] = 16'h0555;
    step(5);
    pulse_start();
    step(200);
    check("post_reset_data", data_out, 12'h555);
    check("post_reset_lead", lead_err, 1'b0);

    // Short period: triggers at 150,300,... ; frames at 150,450,750,1050, misses between
    base2 = n_ticks2;
    enable2 = 1'b1;
    step(155);
    check("dut2_first_frame_cs", cs2, 1'b0);
    check("dut2_first_frame_busy", busy2, 1'b1);
    check("dut2_missed_before", missed2, 1'b0);
    step(150);
    check("dut2_missed_after", missed2, 1'b1);
    step(995);
    check("dut2_frames", n_ticks2 - base2, 4);
    enable2 = 1'b0;
    step(1);
    check("dut2_missed_cleared", missed2, 1'b0);
    step(10);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
